atm_ledger_arbiter: RTL
=======================

// Module: atm_ledger_arbiter
// PURPOSE
//  Round-robin arbiter and read-modify-write sequencer that shares one single-port account-balance ledger between N_REQ ATM session controllers.
//  Each granted request runs atomically to completion: balance query, withdraw, deposit or account-to-account transfer.
//  Sits between the per-terminal ATM FSMs and the ledger RAM. Funds checks are done here, so the session FSMs never touch the RAM directly.
// PARAMETERS
//  N_REQ   2      number of requesting ATM sessions (>=2)
//  ADDR_W  4      ledger index width (2**ADDR_W accounts)
//  BAL_W   16     balance/amount width, unsigned
//  MAX_WD  10000  per-operation debit cap (used only with ATM_WITHDRAW_LIMIT_EN)
// PORTS
//  clk          in   1             clock, rising edge
//  rst_n        in   1             asynchronous active-low reset
//  req          in   N_REQ         request valid, one bit per session
//  req_op       in   2*N_REQ       op per session: 00 query, 01 withdraw, 10 deposit, 11 transfer
//  req_src      in   ADDR_W*N_REQ  source/primary account index per session
//  req_dst      in   ADDR_W*N_REQ  destination index per session (transfer only)
//  req_amt      in   BAL_W*N_REQ   amount per session
//  gnt          out  N_REQ         one-cycle accept pulse, one-hot
//  done         out  1             one-cycle completion pulse
//  done_id      out  $clog2(N_REQ) session that owns the done pulse
//  rsp_balance  out  BAL_W         resulting balance, valid with done
//  rsp_error    out  1             operation rejected, valid with done
//  busy         out  1             high from grant cycle +1 until done inclusive
//  mem_addr     out  ADDR_W        ledger address
//  mem_rd_en    out  1             ledger read; mem_rdata valid the following cycle
//  mem_rdata    in   BAL_W         ledger read data
//  mem_wr_en    out  1             ledger write strobe
//  mem_wdata    out  BAL_W         ledger write data
// BEHAVIOUR
//  - Reset: all outputs 0, FSM to IDLE, RR pointer to 0. Reset takes effect immediately, with no pending write.
//  - Handshake: a session holds req and its fields stable until it sees its gnt. Fields are latched on the gnt cycle.
//    After gnt, the session drops or re-arms req. The session then waits for done with done_id equal to its own index.
//  - Grants are issued only in IDLE. Arbitration starts at the RR pointer and scans upward with wrap; the first asserted req wins.
//    After a grant to session i, the pointer becomes (i+1) mod N_REQ. No grant is issued while busy.
//  - FSM: IDLE -> RD_SRC -> CHK_SRC -> {DONE | WR_SRC | RD_DST}; RD_DST -> CHK_DST -> {DONE | WR_SRC}; WR_SRC -> {DONE | WR_DST}; WR_DST -> DONE -> IDLE.
//  - Latency from the gnt cycle T to the done cycle:
//    query T+3; withdraw/deposit T+4; transfer T+7; any error path T+3 (or T+5 if detected in CHK_DST).
//  - Error conditions:
//    withdraw with amt > bal; deposit with bal+amt > 2**BAL_W-1 (BAL_W+1-bit compare);
//    transfer with src==dst, amt > src bal, or dst overflow.
//    On error there is no write, and rsp_balance holds the unmodified source balance.
//  - Transfer writes both accounts only after both checks pass. Write order is WR_SRC then WR_DST.
//    Reset between the two writes is the only non-atomic window; ledger is re-initialised on system reset.
//  - rsp_balance: query = read value; withdraw/deposit = new value; transfer = new source balance.
//  - amt=0 is legal for every op and produces no error. Its write-back equals the old value.
//  - mem_rd_en and mem_wr_en are never high in the same cycle. mem_addr is held at 0 in IDLE.
// CONFIGURATION
//  ATM_WITHDRAW_LIMIT_EN defined: withdraw or transfer with amt > MAX_WD is rejected at CHK_SRC (error, no write, done T+3).
//  Undefined: no cap is applied and the MAX_WD parameter is ignored.
// TESTING (ledger preload: [2]=20000, [5]=1000, [7]=65000; N_REQ=2)
//  1. s0 query idx2 -> gnt[0] at T, done at T+3, done_id=0, rsp_balance=20000, rsp_error=0, no mem_wr_en.
//  2. s0 withdraw 10000 idx2 -> done at T+4, mem write [2]=10000, rsp_balance=10000.
//     Then withdraw 25000 -> rsp_error=1, no write, rsp_balance=10000.
//  3. s1 transfer 5000 idx2->idx5 -> done at T+7, [2]=5000, [5]=6000, rsp_balance=5000.
//     Transfer idx2->idx2 -> error, done at T+3. Deposit 1000 to idx7 -> error (overflow), [7] unchanged.
//  4. req[0] and req[1] held high continuously from reset -> grant order 0,1,0,1; no back-to-back grant without an intervening done.
//  5. rst_n low in WR_SRC cycle of a transfer -> outputs 0 same cycle, [dst] unchanged, FSM IDLE, next grant goes to s0.
//  6. With ATM_WITHDRAW_LIMIT_EN and MAX_WD=10000: withdraw 10001 from idx7 -> error, no write.
//     Without the macro, the same withdraw succeeds and [7]=54999.

Source files
------------

// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter + RMW sequencer sharing one ledger RAM.
// Optional macro ATM_WITHDRAW_LIMIT_EN caps debits at MAX_WD.
module atm_ledger_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 4,
  parameter int BAL_W  = 16,
  parameter int MAX_WD = 10000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [2*N_REQ-1:0]        req_op,
  input  logic [ADDR_W*N_REQ-1:0]   req_src,
  input  logic [ADDR_W*N_REQ-1:0]   req_dst,
  input  logic [BAL_W*N_REQ-1:0]    req_amt,
  output logic [N_REQ-1:0]          gnt,
  output logic                      done,
  output logic [$clog2(N_REQ)-1:0]  done_id,
  output logic [BAL_W-1:0]          rsp_balance,
  output logic                      rsp_error,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd_en,
  input  logic [BAL_W-1:0]          mem_rdata,
  output logic                      mem_wr_en,
  output logic [BAL_W-1:0]          mem_wdata
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [1:0] OP_QRY = 2'd0;
  localparam logic [1:0] OP_WD  = 2'd1;
  localparam logic [1:0] OP_DEP = 2'd2;
  localparam logic [1:0] OP_XFR = 2'd3;
  localparam logic [BAL_W:0] MAXW = (BAL_W+1)'(MAX_WD);
`ifdef ATM_WITHDRAW_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, RD_SRC, CHK_SRC, RD_DST,
    CHK_DST, WR_SRC, WR_DST, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic               live_q;
  logic [IDW-1:0]     own_q;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  src_q, dst_q;
  logic [BAL_W-1:0]   amt_q;
  logic [BAL_W-1:0]   sbal_q, snew_q, dnew_q;
  logic               err_q;

  logic               hit, take;
  logic [IDW-1:0]     win;
  int                 idx;
  logic [BAL_W:0]     sum_s;
  logic [BAL_W-1:0]   dif_s;
  logic               short_s, lim_s, src_err, dst_err;

  // rotating priority scan starting at the RR pointer
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = IDW'(idx);
      end
    end
  end

  assign take = (state_q == IDLE) && live_q && hit;

  // one-hot accept pulse for the winner
  always_comb begin
    gnt = '0;
    if (take) gnt[win] = 1'b1;
  end

  // funds and overflow checks against the word just read
  always_comb begin
    sum_s   = {1'b0, mem_rdata} + {1'b0, amt_q};
    dif_s   = mem_rdata - amt_q;
    short_s = amt_q > mem_rdata;
    lim_s   = LIM_EN && ({1'b0, amt_q} > MAXW);
    dst_err = sum_s[BAL_W];
    src_err = 1'b0;
    unique case (1'b1)
      op_q == OP_WD:  src_err = short_s | lim_s;
      op_q == OP_DEP: src_err = sum_s[BAL_W];
      op_q == OP_XFR: src_err = (src_q == dst_q) | short_s | lim_s;
      default:        src_err = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state sequencing of the RMW flow
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = RD_SRC;
      RD_SRC:  state_d = CHK_SRC;
      CHK_SRC: begin
        if (op_q == OP_QRY || src_err) state_d = DONE;
        else if (op_q == OP_XFR)       state_d = RD_DST;
        else                           state_d = WR_SRC;
      end
      RD_DST:  state_d = CHK_DST;
      CHK_DST: state_d = dst_err ? DONE : WR_SRC;
      WR_SRC:  state_d = (op_q == OP_XFR) ? WR_DST : DONE;
      WR_DST:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant bookkeeping, request latch and balance registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      live_q <= 1'b0;
      own_q  <= '0;
      op_q   <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      amt_q  <= '0;
      sbal_q <= '0;
      snew_q <= '0;
      dnew_q <= '0;
      err_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (take) begin
        ptr_q <= (win == IDW'(N_REQ-1)) ? '0 : win + IDW'(1);
        own_q <= win;
        op_q  <= req_op[2*win +: 2];
        src_q <= req_src[ADDR_W*win +: ADDR_W];
        dst_q <= req_dst[ADDR_W*win +: ADDR_W];
        amt_q <= req_amt[BAL_W*win +: BAL_W];
        err_q <= 1'b0;
      end
      if (state_q == CHK_SRC) begin
        sbal_q <= mem_rdata;
        snew_q <= (op_q == OP_DEP) ? sum_s[BAL_W-1:0] : dif_s;
        err_q  <= src_err;
      end
      if (state_q == CHK_DST) begin
        dnew_q <= sum_s[BAL_W-1:0];
        err_q  <= dst_err;
      end
    end
  end

  // outputs decoded from state so reset clears them at once
  always_comb begin
    done        = (state_q == DONE);
    busy        = (state_q != IDLE);
    done_id     = done ? own_q : '0;
    rsp_error   = done & err_q;
    rsp_balance = '0;
    if (done)
      rsp_balance = (err_q || op_q == OP_QRY) ? sbal_q : snew_q;
    mem_rd_en   = (state_q == RD_SRC) || (state_q == RD_DST);
    mem_wr_en   = (state_q == WR_SRC) || (state_q == WR_DST);
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (1'b1)
      state_q == RD_SRC: mem_addr = src_q;
      state_q == RD_DST: mem_addr = dst_q;
      state_q == WR_SRC: begin
        mem_addr  = src_q;
        mem_wdata = snew_q;
      end
      state_q == WR_DST: begin
        mem_addr  = dst_q;
        mem_wdata = dnew_q;
      end
      default: ;
    endcase
  end

endmodule
